mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied instruction-request cycles before instruction fetch is forced.
REQ-002 SHALL have parameter LED_BASE, default 16'h0200, byte address of the LED register window.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req / i_addr  input  1 / 16  instruction read request and byte address.
REQ-006 i_gnt / i_rvalid / i_rdata  output  1 / 1 / 16  instruction grant, read-data valid, read data.
REQ-007 d_req / d_we / d_addr / d_wdata  input  1 / 2 / 16 / 16  data request; d_we[1] writes the upper byte [15:8], d_we[0] writes the lower byte [7:0]; d_we==0 means read.
REQ-008 d_gnt / d_rvalid / d_rdata  output  1 / 1 / 16  data grant, read valid, read data.
REQ-009 h_req / h_we / h_addr / h_wdata  input  1 / 2 / 16 / 16  host loader/dump port, same encoding as the data port.
REQ-010 h_gnt / h_rvalid / h_rdata  output  1 / 1 / 16  host grant, read valid, read data.
REQ-011 m_en / m_we / m_addr / m_wdata  output  1 / 2 / 15 / 16  single-port SRAM enable, byte write enables, word address, write data.
REQ-012 m_rdata  input  16  SRAM read data, valid one cycle after the m_en read cycle.
REQ-013 led  output  24  LED register {led_hi, led_mid, led_lo}.

Function
REQ-014 SHALL assert at most one of i_gnt/d_gnt/h_gnt per cycle; each grant is combinational from the current requests and state.
REQ-015 Priority order SHALL be host > data > instruction, except when the starvation counter equals STARVE_LIMIT; then the instruction port is granted over all others.
REQ-016 The starvation counter SHALL increment when i_req is high and i_gnt is low, saturate at STARVE_LIMIT, and clear on i_gnt or when i_req is low.
REQ-017 Word address SHALL be addr[15:1]; addr[0] is ignored for all ports.
REQ-018 A granted request with addr[15:2]==LED_BASE[15:2] SHALL bypass SRAM (m_en=0).
REQ-019 At LED_BASE, we[1] SHALL write wdata[15:8] to led[15:8] and we[0] SHALL write wdata[7:0] to led[7:0]; at LED_BASE+2, we[0] SHALL write wdata[7:0] to led[23:16] and we[1] is ignored.
REQ-020 LED reads SHALL return led[15:0] at LED_BASE and {8'h00,led[23:16]} at LED_BASE+2.
REQ-021 Instruction-port accesses to the LED window SHALL be treated as reads.
REQ-022 Other granted accesses SHALL drive m_en=1, m_addr, m_wdata=wdata, and m_we=we (always 0 for instruction grants).
REQ-023 Read latency SHALL be exactly 1 cycle: the granted port's rvalid is high in the cycle after the grant, with rdata taken from m_rdata or the registered LED value.
REQ-024 A 2-bit routing register SHALL record NONE/I/D/H for the granted port and steer rdata/rvalid accordingly.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Back-to-back grants to any ports SHALL be accepted every cycle, with no bubble.
REQ-027 Requesters hold req and address stable until gnt; a request dropped without a grant SHALL be discarded with no side effects.
REQ-028 rdata outputs of non-selected ports SHALL hold their last value.

Reset
REQ-029 While rst is high, all gnt, rvalid, m_en and m_we SHALL be 0, all rdata 16'h0000, led 24'h0, starvation counter 0, routing register NONE.
REQ-030 If rst is asserted during the cycle after a read grant, that rvalid SHALL be suppressed.
REQ-031 Requests presented while rst is high SHALL NOT be granted.

Verification
REQ-032 i_req with i_addr=16'h0010, no other requests; SRAM word 8 = 16'hABCD -> i_gnt same cycle, m_addr=15'h0008; next cycle i_rvalid=1, i_rdata=16'hABCD.
REQ-033 d_req write d_addr=16'h0200, d_we=2'b11, d_wdata=16'h1234 -> m_en=0, led=24'h001234; then d_we=2'b01, d_addr=16'h0202, d_wdata=16'h0056 -> led=24'h561234; a read at 16'h0202 returns 16'h0056.
REQ-034 i_req and d_req held high for 6 cycles, d_req re-presented each cycle -> d granted in cycles 0-3, i granted in cycle 4, counter cleared, d granted in cycle 5.
REQ-035 h_req, d_req and i_req in the same cycle, counter 0 -> only h_gnt; h write h_we=2'b10, h_wdata=16'hBEEF to 16'h8000 -> m_we=2'b10, m_addr=15'h4000.
REQ-036 d read granted, rst pulsed in the following cycle -> d_rvalid stays 0, led=0, no grants during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates instruction, data and host ports onto one SRAM and decodes a 3-byte LED register window.
// Latency: grant is combinational in the request cycle; read data and rvalid appear exactly one cycle after the grant.
// Backpressure: a losing requester stays ungranted until it wins; starved instruction fetch is forced after STARVE_LIMIT denials.
module mem_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [15:0] LED_BASE     = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,

    input  logic        d_req,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,

    input  logic        h_req,
    input  logic [1:0]  h_we,
    input  logic [15:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [15:0] h_rdata,

    output logic        m_en,
    output logic [1:0]  m_we,
    output logic [14:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,

    output logic [23:0] led
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_I    = 2'd1,
        R_D    = 2'd2,
        R_H    = 2'd3
    } route_t;

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          any_gnt;
    logic [14:0]   sel_word;
    logic [1:0]    sel_we;
    logic [15:0]   sel_wdata;
    route_t        sel_route;
    logic          led_hit;
    logic          is_write;

    route_t        route;
    logic          rd_led;
    logic [15:0]   led_rd_dat;
    logic [15:0]   rd_src;
    logic [23:0]   led_q;
    logic [15:0]   i_rdata_q;
    logic [15:0]   d_rdata_q;
    logic [15:0]   h_rdata_q;

    // Byte address bit 0 never participates in word addressing.
    wire unused_addr_lsb = ^{i_addr[0], d_addr[0], h_addr[0]};

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    // Fixed priority host > data > instruction, overridden by a starved instruction port; nothing granted in reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!rst) begin
            if (i_req && starved)
                i_gnt = 1'b1;
            else if (h_req)
                h_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
            else if (i_req)
                i_gnt = 1'b1;
        end
    end

    assign any_gnt = i_gnt | d_gnt | h_gnt;

    // Steer the winning port's address, enables and data; instruction accesses are always reads.
    always_comb begin
        sel_word  = i_addr[15:1];
        sel_we    = 2'b00;
        sel_wdata = 16'h0000;
        sel_route = R_NONE;
        if (h_gnt) begin
            sel_word  = h_addr[15:1];
            sel_we    = h_we;
            sel_wdata = h_wdata;
            sel_route = R_H;
        end else if (d_gnt) begin
            sel_word  = d_addr[15:1];
            sel_we    = d_we;
            sel_wdata = d_wdata;
            sel_route = R_D;
        end else if (i_gnt) begin
            sel_route = R_I;
        end
    end

    // sel_word[14:1] is byte address [15:2]; sel_word[0] picks the low/high LED word.
    assign led_hit  = (sel_word[14:1] == LED_BASE[15:2]);
    assign is_write = |sel_we;

    assign m_en    = any_gnt && !led_hit;
    assign m_we    = m_en ? sel_we : 2'b00;
    assign m_addr  = sel_word;
    assign m_wdata = sel_wdata;

    // Starvation counter: counts denied instruction cycles, saturates, clears on grant or idle.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!i_req || i_gnt)
            starve_cnt <= '0;
        else if (!starved)
            starve_cnt <= starve_cnt + CW'(1);
    end

    // LED register writes: low word is byte-laned, high word only has its low byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 24'h0;
        end else if (any_gnt && led_hit) begin
            if (!sel_word[0]) begin
                if (sel_we[1]) led_q[15:8] <= sel_wdata[15:8];
                if (sel_we[0]) led_q[7:0]  <= sel_wdata[7:0];
            end else if (sel_we[0]) begin
                led_q[23:16] <= sel_wdata[7:0];
            end
        end
    end

    // Remember which port issued a read and whether the answer comes from the LED window.
    always_ff @(posedge clk) begin
        if (rst) begin
            route      <= R_NONE;
            rd_led     <= 1'b0;
            led_rd_dat <= 16'h0000;
        end else begin
            route      <= (any_gnt && !is_write) ? sel_route : R_NONE;
            rd_led     <= led_hit;
            led_rd_dat <= sel_word[0] ? {8'h00, led_q[23:16]} : led_q[15:0];
        end
    end

    assign rd_src = rd_led ? led_rd_dat : m_rdata;

    // Hold each port's last returned word so idle ports keep a stable rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
            h_rdata_q <= 16'h0000;
        end else begin
            if (route == R_I) i_rdata_q <= rd_src;
            if (route == R_D) d_rdata_q <= rd_src;
            if (route == R_H) h_rdata_q <= rd_src;
        end
    end

    // Reset masks any read that was in flight when it arrived.
    assign i_rvalid = !rst && (route == R_I);
    assign d_rvalid = !rst && (route == R_D);
    assign h_rvalid = !rst && (route == R_H);

    assign i_rdata = rst ? 16'h0000 : (i_rvalid ? rd_src : i_rdata_q);
    assign d_rdata = rst ? 16'h0000 : (d_rvalid ? rd_src : d_rdata_q);
    assign h_rdata = rst ? 16'h0000 : (h_rvalid ? rd_src : h_rdata_q);

    assign led = rst ? 24'h0 : led_q;

endmodule
